ymat_rx: RTL and testbench



---
 rtl/ymat_rx_if.sv | 26 ++
 rtl/ymat_rx.sv | 161 ++++++++++++++++
 tb/tb_ymat_rx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ymat_rx_if.sv
// Stream-in and random-access read-out bundle for the ymat_rx frame collector.
// The master side is the producer/consumer; the slave side is the collector.
interface ymat_rx_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) ();
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_im;
    logic          in_ready;
    logic          rd_ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_real;
    logic [DW-1:0] rd_im;

    modport master (
        output in_valid, in_sof, in_real, in_im, rd_ack, rd_addr,
        input  in_ready, rd_real, rd_im
    );

    modport slave (
        input  in_valid, in_sof, in_real, in_im, rd_ack, rd_addr,
        output in_ready, rd_real, rd_im
    );
endinterface

// File: rtl/ymat_rx.sv
// Collects one ROWS*COLS frame of complex samples, holds it until acknowledged and
// serves indexed reads. Optional frame-energy accumulator enabled by YMAT_POWER_EN.
module ymat_rx #(
    parameter int unsigned DW   = 16,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 2,
    parameter int unsigned AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    ymat_rx_if.slave          bus,
    output logic              full,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overflow,
    output logic [2*DW+3:0]   power
);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = 2 * DW + 4;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;
    logic          complete;
    logic          ovf_set;
    logic          release_frame;

    logic [DW-1:0] mem_re [DEPTH];
    logic [DW-1:0] mem_im [DEPTH];

    // State and write-index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Accept/resync/complete/release decisions
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        wr_en         = 1'b0;
        wr_idx        = idx;
        complete      = 1'b0;
        ovf_set       = 1'b0;
        release_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                end
            end
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = bus.in_sof ? '0 : idx;
                end
            end
            ST_FULL: begin
                ovf_set = bus.in_valid;
                if (bus.rd_ack) begin
                    release_frame = 1'b1;
                    state_nx      = ST_IDLE;
                    idx_nx        = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = '0;
            end
        endcase
        // A write to the last slot closes the frame, including N=1 and resync-at-N=1
        if (wr_en) begin
            if (wr_idx == LAST) begin
                complete = 1'b1;
                state_nx = ST_FULL;
                idx_nx   = '0;
            end else begin
                state_nx = ST_COLLECT;
                idx_nx   = wr_idx + AW'(1);
            end
        end
    end

    // Sample buffer, read port and frame status
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_re      <= '{default: '0};
            mem_im      <= '{default: '0};
            bus.rd_real <= '0;
            bus.rd_im   <= '0;
            bus.in_ready <= 1'b1;
            full        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_re[wr_idx] <= bus.in_real;
                mem_im[wr_idx] <= bus.in_im;
            end
            // Same-cycle write and read of one slot returns the pre-write value
            if (32'(bus.rd_addr) < N) begin
                bus.rd_real <= mem_re[bus.rd_addr];
                bus.rd_im   <= mem_im[bus.rd_addr];
            end else begin
                bus.rd_real <= '0;
                bus.rd_im   <= '0;
            end
            bus.in_ready <= (state_nx != ST_FULL);
            frame_done   <= complete;
            if (complete) begin
                full      <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (release_frame) begin
                full <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef YMAT_POWER_EN
    logic signed [2*DW-1:0] sq_re;
    logic signed [2*DW-1:0] sq_im;
    logic [PW-1:0]          term;

    always_comb begin
        sq_re = $signed(bus.in_real) * $signed(bus.in_real);
        sq_im = $signed(bus.in_im) * $signed(bus.in_im);
        term  = PW'($unsigned(sq_re)) + PW'($unsigned(sq_im));
    end

    // Energy restarts whenever slot 0 is written (frame start or resync)
    always_ff @(posedge clk) begin
        if (rst) begin
            power <= '0;
        end else if (wr_en) begin
            power <= (wr_idx == '0) ? term : power + term;
        end
    end
`else
    assign power = '0;
`endif

endmodule

// File: tb/tb_ymat_rx.sv
// Directed, table-driven bench for ymat_rx (default 4x2 build plus a 4x1 build
// for out-of-range reads); power checks follow YMAT_POWER_EN.
module tb_ymat_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        full, frame_done, overflow;
    logic [7:0]  frame_cnt;
    logic [35:0] power;
    logic        full2, done2, ovf2;
    logic [7:0]  cnt2;
    logic [35:0] pw2;

    int checks = 0;
    int errors = 0;

    ymat_rx_if #(.DW(16), .AW(3)) bus ();
    ymat_rx_if #(.DW(16), .AW(3)) bus2 ();

    ymat_rx #(.DW(16), .ROWS(4), .COLS(2), .AW(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .full(full), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .overflow(overflow), .power(power)
    );

    ymat_rx #(.DW(16), .ROWS(4), .COLS(1), .AW(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .full(full2), .frame_done(done2),
        .frame_cnt(cnt2), .overflow(ovf2), .power(pw2)
    );

    always #5 clk = ~clk;

`ifdef YMAT_POWER_EN
    localparam logic [35:0] PWR_ONE  = 36'h0_0002_0000;
    localparam logic [35:0] PWR_FULL = 36'h0_0010_0000;
`else
    localparam logic [35:0] PWR_ONE  = 36'h0;
    localparam logic [35:0] PWR_FULL = 36'h0;
`endif

    typedef struct {
        logic        v;
        logic        sof;
        logic [15:0] re;
        logic [15:0] im;
        logic        ack;
        logic [2:0]  addr;
        logic        e_ready;
        logic        e_full;
        logic        e_done;
        logic [7:0]  e_cnt;
        logic        e_ovf;
        logic [15:0] e_re;
        logic [15:0] e_im;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic sof, input logic [15:0] re,
                                input logic [15:0] im, input logic ack, input logic [2:0] addr,
                                input logic e_ready, input logic e_full, input logic e_done,
                                input logic [7:0] e_cnt, input logic e_ovf,
                                input logic [15:0] e_re, input logic [15:0] e_im);
        vec_t t;
        t.v = v; t.sof = sof; t.re = re; t.im = im; t.ack = ack; t.addr = addr;
        t.e_ready = e_ready; t.e_full = e_full; t.e_done = e_done; t.e_cnt = e_cnt;
        t.e_ovf = e_ovf; t.e_re = e_re; t.e_im = e_im;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] re, input logic [15:0] im);
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        bus.in_real  = re;
        bus.in_im    = im;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.rd_ack = 1'b1;
        cycle();
        bus.rd_ack = 1'b0;
    endtask

    task automatic chk_status(input string nm, input logic rdy, input logic fl, input logic dn,
                              input logic [7:0] cnt, input logic ov);
        chk({nm, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
        chk({nm, ".full"}, 64'(full), 64'(fl));
        chk({nm, ".frame_done"}, 64'(frame_done), 64'(dn));
        chk({nm, ".frame_cnt"}, 64'(frame_cnt), 64'(cnt));
        chk({nm, ".overflow"}, 64'(overflow), 64'(ov));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_real = '0; bus.in_im = '0;
        bus.rd_ack = 1'b0; bus.rd_addr = '0;
        bus2.in_valid = 1'b0; bus2.in_sof = 1'b0; bus2.in_real = '0; bus2.in_im = '0;
        bus2.rd_ack = 1'b0; bus2.rd_addr = '0;

        // Frame 1: real=k, im=-k, reading slot 5 throughout
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, 16'(k), 16'(-k), 0, 3'd5, k != 7, k == 7, k == 7,
                              (k == 7) ? 8'd1 : 8'd0, 0,
                              (k >= 6) ? 16'h0005 : 16'h0, (k >= 6) ? 16'hFFFB : 16'h0));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd5, 0, 1, 0, 8'd1, 0, 16'h0005, 16'hFFFB));
        // Samples offered while FULL are dropped
        vecs.push_back(mk(1, 0, 16'h7777, 16'h7777, 0, 3'd3, 0, 1, 0, 8'd1, 1, 16'h0003, 16'hFFFD));
        vecs.push_back(mk(1, 1, 16'h7777, 16'h7777, 0, 3'd0, 0, 1, 0, 8'd1, 1, 16'h0000, 16'h0000));
        // Release with a simultaneous sample: dropped, overflow stays
        vecs.push_back(mk(1, 0, 16'h7777, 16'h7777, 1, 3'd7, 1, 0, 0, 8'd1, 1, 16'h0007, 16'hFFF9));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd7, 1, 0, 0, 8'd1, 1, 16'h0007, 16'hFFF9));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 1, 3'd7, 1, 0, 0, 8'd1, 1, 16'h0007, 16'hFFF9));
        // Frame 2: three gapped samples, then resync with 0x0100
        vecs.push_back(mk(1, 0, 16'h0011, 16'h0021, 0, 3'd0, 1, 0, 0, 8'd1, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd0, 1, 0, 0, 8'd1, 1, 16'h0011, 16'h0021));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd0, 1, 0, 0, 8'd1, 1, 16'h0011, 16'h0021));
        vecs.push_back(mk(1, 0, 16'h0012, 16'h0022, 0, 3'd1, 1, 0, 0, 8'd1, 1, 16'h0001, 16'hFFFF));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd1, 1, 0, 0, 8'd1, 1, 16'h0012, 16'h0022));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd1, 1, 0, 0, 8'd1, 1, 16'h0012, 16'h0022));
        vecs.push_back(mk(1, 0, 16'h0013, 16'h0023, 0, 3'd2, 1, 0, 0, 8'd1, 1, 16'h0002, 16'hFFFE));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd2, 1, 0, 0, 8'd1, 1, 16'h0013, 16'h0023));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd2, 1, 0, 0, 8'd1, 1, 16'h0013, 16'h0023));
        vecs.push_back(mk(1, 1, 16'h0100, 16'h0200, 0, 3'd0, 1, 0, 0, 8'd1, 1, 16'h0011, 16'h0021));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd0, 1, 0, 0, 8'd1, 1, 16'h0100, 16'h0200));
        for (int j = 1; j < 8; j++)
            vecs.push_back(mk(1, 0, 16'(32'h30 + j), 16'(32'h40 + j), 0, 3'd7, j != 7, j == 7,
                              j == 7, (j == 7) ? 8'd2 : 8'd1, 1, 16'h0007, 16'hFFF9));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd7, 0, 1, 0, 8'd2, 1, 16'h0037, 16'h0047));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd2, 0, 1, 0, 8'd2, 1, 16'h0032, 16'h0042));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 0, 3'd0, 0, 1, 0, 8'd2, 1, 16'h0100, 16'h0200));
        vecs.push_back(mk(0, 0, 16'h0, 16'h0, 1, 3'd0, 1, 0, 0, 8'd2, 1, 16'h0100, 16'h0200));

        // Reset state
        cycle();
        cycle();
        chk_status("reset", 1, 0, 0, 8'd0, 0);
        chk("reset.rd_real", 64'(bus.rd_real), 64'h0);
        chk("reset.rd_im", 64'(bus.rd_im), 64'h0);
        chk("reset.power", 64'(power), 64'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.in_valid = vecs[i].v;
            bus.in_sof   = vecs[i].sof;
            bus.in_real  = vecs[i].re;
            bus.in_im    = vecs[i].im;
            bus.rd_ack   = vecs[i].ack;
            bus.rd_addr  = vecs[i].addr;
            cycle();
            chk_status($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_full,
                       vecs[i].e_done, vecs[i].e_cnt, vecs[i].e_ovf);
            chk($sformatf("vec%0d.rd_real", i), 64'(bus.rd_real), 64'(vecs[i].e_re));
            chk($sformatf("vec%0d.rd_im", i), 64'(bus.rd_im), 64'(vecs[i].e_im));
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.rd_ack = 1'b0;

        // Reset mid-frame discards everything
        for (int k = 0; k < 4; k++) feed(16'h0A00, 16'h0B00);
        rst = 1'b1;
        bus.rd_addr = 3'd0;
        cycle();
        rst = 1'b0;
        chk_status("midrst", 1, 0, 0, 8'd0, 0);
        chk("midrst.power", 64'(power), 64'h0);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            cycle();
            chk($sformatf("midrst.buf%0d", a), 64'({bus.rd_real, bus.rd_im}), 64'h0);
        end
        bus.rd_addr = 3'd0;
        for (int k = 0; k < 8; k++) feed(16'(32'h200 + k), 16'(32'h300 + k));
        chk_status("postrst", 0, 1, 1, 8'd1, 0);
        bus.rd_addr = 3'd4;
        cycle();
        chk("postrst.done_pulse", 64'(frame_done), 64'h0);
        chk("postrst.rd4", 64'({bus.rd_real, bus.rd_im}), 64'h0204_0304);
        bus.rd_addr = 3'd0;
        cycle();
        chk("postrst.rd0", 64'({bus.rd_real, bus.rd_im}), 64'h0200_0300);
        ack();

        // Frame counter wrap
        for (int f = 0; f < 254; f++) begin
            for (int k = 0; k < 8; k++) feed(16'(f), 16'(k));
            ack();
        end
        chk("wrap.cnt255", 64'(frame_cnt), 64'd255);
        for (int k = 0; k < 8; k++) feed(16'h1, 16'h1);
        chk_status("wrap", 0, 1, 1, 8'd0, 0);
        ack();

        // Frame energy, positive then negative samples
        feed(16'h0100, 16'h0100);
        chk("pwr.first", 64'(power), 64'(PWR_ONE));
        for (int k = 1; k < 8; k++) feed(16'h0100, 16'h0100);
        chk("pwr.full", 64'(full), 64'h1);
        chk("pwr.pos", 64'(power), 64'(PWR_FULL));
        feed(16'h7FFF, 16'h7FFF);
        chk("pwr.hold", 64'(power), 64'(PWR_FULL));
        chk("pwr.ovf", 64'(overflow), 64'h1);
        ack();
        for (int k = 0; k < 8; k++) feed(16'hFF00, 16'hFF00);
        chk("pwr.neg", 64'(power), 64'(PWR_FULL));
        ack();

        // 4x1 build: out-of-range addresses read as zero
        for (int j = 0; j < 4; j++) begin
            bus2.in_valid = 1'b1;
            bus2.in_real  = 16'(32'h55 + j);
            bus2.in_im    = 16'(32'h65 + j);
            cycle();
        end
        bus2.in_valid = 1'b0;
        chk("n4.full", 64'(full2), 64'h1);
        chk("n4.cnt", 64'(cnt2), 64'h1);
        bus2.rd_addr = 3'd3;
        cycle();
        chk("n4.rd3", 64'({bus2.rd_real, bus2.rd_im}), 64'h0058_0068);
        bus2.rd_addr = 3'd5;
        cycle();
        chk("n4.rd5", 64'({bus2.rd_real, bus2.rd_im}), 64'h0);
        bus2.rd_addr = 3'd7;
        cycle();
        chk("n4.rd7", 64'({bus2.rd_real, bus2.rd_im}), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
